det_matrix_feeder: RTL

Host-side companion of the 2×2 determinant calculator. It accepts four 8-bit matrix elements from a host stream and stores them in a small register-file memory. It then serves that memory to the calculator's address/data read port, pulses the calculator's `start`, waits for `done`, and hands the 16-bit determinant back to the host over a valid/ready handshake. In the top level it sits between the host bus and the calculator, driving the calculator's `data_in`, `start` and `start_adress`, and consuming its `adress`, `out_put` and `done`.

---
 rtl/det_matrix_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/det_matrix_feeder.sv
// Host-side feeder for the 2x2 determinant calculator.
// Collects four elements from the host into a small register-file memory, serves them to the
// calculator's read port, pulses start, waits for done, and returns the determinant to the host.
// Optional feature macro: FEEDER_DOUBLE_BUFFER_EN (two ping-pong banks, load next matrix while
// the current one is being computed). Default build uses bank 0 only.
module det_matrix_feeder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RES_W  = 16,
    parameter int unsigned ELEMS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [2:0]        adress,
    output logic [DATA_W-1:0] data_out,
    output logic              start,
    output logic [2:0]        start_adress,
    input  logic              done,
    input  logic [RES_W-1:0]  det_in,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int unsigned Depth   = 2 * ELEMS;
    localparam logic [1:0]  LastIdx = 2'(ELEMS - 1);

    localparam logic [1:0] StFill   = 2'd0;
    localparam logic [1:0] StStart  = 2'd1;
    localparam logic [1:0] StBusy   = 2'd2;
    localparam logic [1:0] StResult = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic              fbank_q, fbank_d;
    logic              abank_q, abank_d;
    logic [1:0]        full_q, full_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];

    logic wr_fire;
    logic fill_done;
    logic release_bank;

    assign wr_fire      = wr_valid && wr_ready;
    assign fill_done    = wr_fire && (wcnt_q == LastIdx);
    // The active bank is handed back to the host once its result has been taken.
    assign release_bank = (state_q == StResult) && result_ready;

`ifdef FEEDER_DOUBLE_BUFFER_EN
    logic other_full;
    // Other bank already full, or completing on this very edge.
    assign other_full = full_q[~abank_q] || (fill_done && (fbank_q != abank_q));
    assign wr_ready   = !full_q[fbank_q];
    assign data_out   = mem_q[adress];
`else
    logic unused_bank;
    assign unused_bank = adress[2];
    assign wr_ready    = (state_q == StFill);
    assign data_out    = mem_q[{1'b0, adress[1:0]}];
`endif

    assign start        = (state_q == StStart);
    assign start_adress = {abank_q, 2'b00};
    assign result       = result_q;
    assign result_valid = (state_q == StResult);

    // Host write path: memory, write counter, fill bank and per-bank full flags.
    always_comb begin
        mem_d   = mem_q;
        wcnt_d  = wcnt_q;
        fbank_d = fbank_q;
        full_d  = full_q;
        if (wr_fire) begin
            mem_d[{fbank_q, wcnt_q}] = wr_data;
            wcnt_d = fill_done ? 2'd0 : wcnt_q + 2'd1;
            if (fill_done) begin
                full_d[fbank_q] = 1'b1;
`ifdef FEEDER_DOUBLE_BUFFER_EN
                fbank_d = ~fbank_q;
`endif
            end
        end
        if (release_bank) begin
            full_d[abank_q] = 1'b0;
        end
    end

    // Control FSM: launch a full bank, wait for done, hold the result until the host takes it.
    always_comb begin
        state_d  = state_q;
        abank_d  = abank_q;
        result_d = result_q;
        case (state_q)
            StFill: begin
                // A bank left full by a completion racing the previous release wins first.
                if (full_q[0]) begin
                    abank_d = 1'b0;
                    state_d = StStart;
                end else if (full_q[1]) begin
                    abank_d = 1'b1;
                    state_d = StStart;
                end else if (fill_done) begin
                    abank_d = fbank_q;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StBusy;
            end
            StBusy: begin
                if (done) begin
                    result_d = det_in;
                    state_d  = StResult;
                end
            end
            StResult: begin
                if (result_ready) begin
`ifdef FEEDER_DOUBLE_BUFFER_EN
                    if (other_full) begin
                        abank_d = ~abank_q;
                        state_d = StStart;
                    end else begin
                        state_d = StFill;
                    end
`else
                    state_d = StFill;
`endif
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StFill;
            wcnt_q   <= 2'd0;
            fbank_q  <= 1'b0;
            abank_q  <= 1'b0;
            full_q   <= 2'b00;
            result_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            fbank_q  <= fbank_d;
            abank_q  <= abank_d;
            full_q   <= full_d;
            result_q <= result_d;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
